pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 168 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each of the WIDTH/SEG stages adds one SEG-bit segment using 4-bit CLA
// groups; the inter-stage carry is registered, unconsumed operand bits are
// skewed forward and finished sum segments travel with the item so the
// result leaves the last stage aligned. The last stage is the output register.
// A single global enable stalls the whole pipe under output backpressure.
// Optional macro CLA_PIPE_SAT_EN: saturate S on signed overflow.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned LAST   = STAGES - 1;

    // SEG-bit add built from 4-bit lookahead groups; each group's carry-out
    // comes from its group generate/propagate, never from bit-level ripple.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG:0]   c;
        logic           cg;
        logic           gg;
        logic           pg;
        int unsigned    bs;
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        cg = ci;
        for (int unsigned gi = 0; gi < SEG / 4; gi++) begin
            bs       = gi * 4;
            c[bs]    = cg;
            c[bs+1]  = g[bs] | (p[bs] & cg);
            c[bs+2]  = g[bs+1] | (p[bs+1] & g[bs]) | (p[bs+1] & p[bs] & cg);
            c[bs+3]  = g[bs+2] | (p[bs+2] & g[bs+1]) | (p[bs+2] & p[bs+1] & g[bs])
                     | (p[bs+2] & p[bs+1] & p[bs] & cg);
            gg = g[bs+3] | (p[bs+3] & g[bs+2]) | (p[bs+3] & p[bs+2] & g[bs+1])
               | (p[bs+3] & p[bs+2] & p[bs+1] & g[bs]);
            pg = &p[bs +: 4];
            cg = gg | (pg & cg);
        end
        c[SEG] = cg;
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage pipeline registers (operands skewed, partial sum deskewed)
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];

    // Per-stage inputs and next-state values
    logic             v_in   [STAGES];
    logic             c_in   [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic [WIDTH-1:0] sum_d  [STAGES];
    logic             cout_d [STAGES];

    // Output register
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] s_d;
    logic             ovf_d;

    assign en        = !(v_q[LAST] && !out_ready);
    assign in_ready  = en;
    assign out_valid = v_q[LAST];
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign b_eff     = Sub ? ~B : B;
    assign cin_eff   = Sub ? 1'b1 : Cin;

    // Route each stage's inputs and add its own segment into the partial sum
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                v_in[k]   = in_valid;
                c_in[k]   = cin_eff;
                a_in[k]   = A;
                b_in[k]   = b_eff;
                sum_in[k] = '0;
            end else begin
                v_in[k]   = v_q[k-1];
                c_in[k]   = c_q[k-1];
                a_in[k]   = a_q[k-1];
                b_in[k]   = b_q[k-1];
                sum_in[k] = sum_q[k-1];
            end
            sum_d[k] = sum_in[k];
            {cout_d[k], sum_d[k][k*SEG +: SEG]} =
                cla_seg(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
        end
    end

    // Signed overflow from effective operand MSBs; optional saturation
    always_comb begin
        ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                (sum_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
        s_d   = sum_d[LAST];
`ifdef CLA_PIPE_SAT_EN
        if (ovf_d) begin
            s_d = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Valid bits and output register: reset-cleared, frozen when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
            end
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
            end
            if (v_in[LAST]) begin
                s_q    <= s_d;
                cout_q <= cout_d[LAST];
                ovf_q  <= ovf_d;
            end
        end
    end

    // Datapath registers: no reset needed, qualified by valid so bubbles hold
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_q[k]   <= a_in[k];
                    b_q[k]   <= b_in[k];
                    sum_q[k] <= sum_d[k];
                    c_q[k]   <= cout_d[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32, SEG=8).
// A queue-based arithmetic model predicts every accepted item; literal
// vectors pin the model and the 4-cycle latency.
module tb_pipelined_cla_adder;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic         Cin, Sub, in_valid, out_ready;
    logic         in_ready, Cout, Ovf, out_valid;
    logic [W-1:0] S;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    res_t exp_q[$];
    res_t e;
    logic         stalled_prev = 1'b0;
    logic [W-1:0] s_prev;

`ifdef CLA_PIPE_SAT_EN
    localparam logic [W-1:0] OVF_POS_S = 32'h7FFFFFFF;
`else
    localparam logic [W-1:0] OVF_POS_S = 32'h80000000;
`endif

    pipelined_cla_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .in_valid(in_valid), .in_ready(in_ready), .S(S), .Cout(Cout),
        .Ovf(Ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        res_t         r;
        logic [W-1:0] be;
        logic [W:0]   t;
        be  = sb ? ~b : b;
        t   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
`ifdef CLA_PIPE_SAT_EN
        if (r.o) r.s = a[W-1] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: sampled mid-cycle, so each valid&&ready is one transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev) check("hold_S", S, s_prev);
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got S=%h with no item outstanding", S);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_S", S, e.s);
                    check("sb_Cout", Cout, e.c);
                    check("sb_Ovf", Ovf, e.o);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, Sub));
            stalled_prev = out_valid && !out_ready;
            s_prev       = S;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    always @(negedge rst_n) exp_q.delete();

    // Present one item (called just after a rising edge); returns after acceptance
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb);
        int g;
        A = a; B = b; Cin = ci; Sub = sb; in_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single item with literal expectations and a latency measurement
    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb, input logic [W-1:0] xs,
                            input logic xc, input logic xo);
        int n;
        push(a, b, ci, sb);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_latency"}, n, 4);
        check({name, "_S"}, S, xs);
        check({name, "_Cout"}, Cout, xc);
        check({name, "_Ovf"}, Ovf, xo);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] va [8] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h12345678,
                             32'h0000FFFF, 32'hFFFF0000, 32'h7FFFFFFF, 32'hDEADBEEF};
    logic [W-1:0] vb [8] = '{32'h00000002, 32'h80000000, 32'h00000001, 32'h12345678,
                             32'h00000001, 32'h0000FFFF, 32'hFFFFFFFF, 32'h01234567};
    logic         vc [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int cnt;
        rst_n = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_Cout", Cout, 0);
        check("rst_Ovf", Ovf, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        directed("add3_5", 32'h3, 32'h5, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0);
        directed("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        directed("cin", 32'h0000ABCD, 32'h00001234, 1'b1, 1'b0, 32'h0000BE02, 1'b0, 1'b0);
        directed("sub5_3", 32'h5, 32'h3, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
        directed("sub3_5", 32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        directed("ovf_pos", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, OVF_POS_S, 1'b0, 1'b1);

        // Eight back-to-back items with a 3-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) push(va[i], vb[i], vc[i], vs[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset with three items in flight: none may surface afterwards
        push(32'h11111111, 32'h1, 1'b0, 1'b0);
        push(32'h22222222, 32'h2, 1'b0, 1'b0);
        push(32'h33333333, 32'h3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("no_stale_after_rst", cnt, 0);
        @(posedge clk);
        #1;
        directed("add_after_rst", 32'h3, 32'h5, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
